// File: rtl/perimeter_driver.sv
// perimeter_driver: issues a programmed sequence of (side_1, side_2) pairs on two
// /dav-rfd producer channels in lockstep, consumes the returned 10-bit perimeter
// and counts values that differ from 2*(side_1+side_2).
//
// state    | meaning
// ---------|-------------------------------------------------------------
// IDLE     | out of reset, waiting for start
// WAIT_RFD | pair loaded, waiting for both consumers to raise rfd
// SEND     | both dav_ low, waiting for both consumers to drop rfd
// GET      | waiting for the perimeter producer to drop dav_in_
// ACK      | rfd_in low, waiting for dav_in_ to return high
// DONE     | run finished, waiting for the next start
module perimeter_driver #(
    parameter int          N_PAIRS = 16,
    parameter logic [7:0]  X_INIT  = 8'd3,
    parameter logic [7:0]  Y_INIT  = 8'd5,
    parameter logic [7:0]  X_STEP  = 8'd1,
    parameter logic [7:0]  Y_STEP  = 8'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  data_out_1,
    output logic        dav_out_1_,
    input  logic        rfd_out_1,
    output logic [7:0]  data_out_2,
    output logic        dav_out_2_,
    input  logic        rfd_out_2,
    input  logic [9:0]  data_in,
    input  logic        dav_in_,
    output logic        rfd_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_count,
    output logic [9:0]  last_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RFD, S_SEND, S_GET, S_ACK, S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_PAIRS - 1);

    state_t      state, state_next;
    logic [7:0]  idx;
    logic        load_first, load_next, capture;
    logic [8:0]  side_sum;
    logic [9:0]  expected;

    // The 9-bit sum keeps the carry so 255+255 still yields 1020.
    assign side_sum = {1'b0, data_out_1} + {1'b0, data_out_2};
    assign expected = {side_sum, 1'b0};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs; dav_ and rfd_in are decoded from state,
    // so both producer channels always move together.
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        capture    = 1'b0;
        dav_out_1_ = 1'b1;
        dav_out_2_ = 1'b1;
        rfd_in     = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_first = 1'b1;
                    state_next = S_WAIT_RFD;
                end
            end
            S_WAIT_RFD: begin
                busy = 1'b1;
                if (rfd_out_1 && rfd_out_2) state_next = S_SEND;
            end
            S_SEND: begin
                busy       = 1'b1;
                dav_out_1_ = 1'b0;
                dav_out_2_ = 1'b0;
                if (!rfd_out_1 && !rfd_out_2) state_next = S_GET;
            end
            S_GET: begin
                busy = 1'b1;
                if (!dav_in_) begin
                    capture    = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                busy   = 1'b1;
                rfd_in = 1'b0;
                if (dav_in_) begin
                    if (idx == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        load_next  = 1'b1;
                        state_next = S_WAIT_RFD;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load_first = 1'b1;
                    state_next = S_WAIT_RFD;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pair generator, result capture and saturating mismatch counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_1  <= X_INIT;
            data_out_2  <= Y_INIT;
            idx         <= 8'd0;
            err_count   <= 8'd0;
            last_result <= 10'd0;
        end else begin
            if (load_first) begin
                data_out_1 <= X_INIT;
                data_out_2 <= Y_INIT;
                idx        <= 8'd0;
                err_count  <= 8'd0;
            end
            if (load_next) begin
                data_out_1 <= data_out_1 + X_STEP;
                data_out_2 <= data_out_2 + Y_STEP;
                idx        <= idx + 8'd1;
            end
            if (capture) begin
                last_result <= data_in;
                if (data_in != expected && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_perimeter_driver.sv
// Directed bench for perimeter_driver: a default instance exercises full runs,
// error counting, channel skew, long producer holds and mid-run reset; a second
// instance with saturated initial sides exercises the carry and wrap boundary.
module tb_perimeter_driver;

    logic       clock = 1'b0;
    logic       reset;

    logic       start, rfd1, rfd2, dav_in_n;
    logic [9:0] din;
    logic [7:0] d1, d2, err;
    logic       dav1, dav2, rfd_in, busy, done;
    logic [9:0] last;

    logic       b_start, b_rfd1, b_rfd2, b_dav_in_n;
    logic [9:0] b_din;
    logic [7:0] b_d1, b_d2, b_err;
    logic       b_dav1, b_dav2, b_rfd_in, b_busy, b_done;
    logic [9:0] b_last;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    perimeter_driver dut_a (
        .clock(clock), .reset(reset), .start(start),
        .data_out_1(d1), .dav_out_1_(dav1), .rfd_out_1(rfd1),
        .data_out_2(d2), .dav_out_2_(dav2), .rfd_out_2(rfd2),
        .data_in(din), .dav_in_(dav_in_n), .rfd_in(rfd_in),
        .busy(busy), .done(done), .err_count(err), .last_result(last)
    );

    perimeter_driver #(
        .N_PAIRS(2), .X_INIT(8'd255), .Y_INIT(8'd255), .X_STEP(8'd1), .Y_STEP(8'd2)
    ) dut_b (
        .clock(clock), .reset(reset), .start(b_start),
        .data_out_1(b_d1), .dav_out_1_(b_dav1), .rfd_out_1(b_rfd1),
        .data_out_2(b_d2), .dav_out_2_(b_dav2), .rfd_out_2(b_rfd2),
        .data_in(b_din), .dav_in_(b_dav_in_n), .rfd_in(b_rfd_in),
        .busy(b_busy), .done(b_done), .err_count(b_err), .last_result(b_last)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full pair against a zero-delay partner; sel picks instance b.
    task automatic pair(input bit sel, input logic [7:0] ex, input logic [7:0] ey,
                        input logic [9:0] ret);
        if (sel) begin b_rfd1 = 1'b1; b_rfd2 = 1'b1; end
        else     begin rfd1 = 1'b1;   rfd2 = 1'b1;   end
        tick();
        chk("send_dav1", sel ? b_dav1 : dav1, 0);
        chk("send_dav2", sel ? b_dav2 : dav2, 0);
        chk("send_x", sel ? b_d1 : d1, ex);
        chk("send_y", sel ? b_d2 : d2, ey);
        if (sel) begin b_rfd1 = 1'b0; b_rfd2 = 1'b0; end
        else     begin rfd1 = 1'b0;   rfd2 = 1'b0;   end
        tick();
        chk("get_dav", sel ? b_dav1 : dav1, 1);
        chk("get_rfd_in", sel ? b_rfd_in : rfd_in, 1);
        if (sel) begin b_din = ret; b_dav_in_n = 1'b0; end
        else     begin din = ret;   dav_in_n = 1'b0;   end
        tick();
        chk("ack_rfd_in", sel ? b_rfd_in : rfd_in, 0);
        chk("ack_last", sel ? b_last : last, ret);
        if (sel) b_dav_in_n = 1'b1;
        else     dav_in_n = 1'b1;
        tick();
        chk("rel_rfd_in", sel ? b_rfd_in : rfd_in, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rfd1 = 1'b0; rfd2 = 1'b0; dav_in_n = 1'b1; din = '0;
        b_start = 1'b0; b_rfd1 = 1'b0; b_rfd2 = 1'b0; b_dav_in_n = 1'b1; b_din = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_dav1", dav1, 1);
        chk("rst_dav2", dav2, 1);
        chk("rst_rfd_in", rfd_in, 1);
        chk("rst_x", d1, 3);
        chk("rst_y", d2, 5);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_last", last, 0);
        chk("rst_b_x", b_d1, 255);
        tick();
        chk("idle_busy", busy, 0);

        // Run 1: ideal partner, 16 pairs.
        start = 1'b1; tick(); start = 1'b0;
        chk("run1_busy", busy, 1);
        chk("run1_done", done, 0);
        for (int i = 0; i < 16; i++)
            pair(1'b0, 8'(3 + i), 8'(5 + 2 * i), 10'(2 * ((3 + i) + (5 + 2 * i))));
        chk("run1_end_done", done, 1);
        chk("run1_end_busy", busy, 0);
        chk("run1_end_err", err, 0);
        chk("run1_end_last", last, 106);

        // Run 2: pair 0 answered with 17 instead of 16.
        start = 1'b1; tick(); start = 1'b0;
        chk("run2_done_clr", done, 0);
        chk("run2_busy", busy, 1);
        pair(1'b0, 8'd3, 8'd5, 10'd17);
        chk("run2_err_after0", err, 1);
        for (int i = 1; i < 16; i++)
            pair(1'b0, 8'(3 + i), 8'(5 + 2 * i), 10'(2 * ((3 + i) + (5 + 2 * i))));
        chk("run2_end_err", err, 1);
        chk("run2_end_last", last, 106);
        chk("run2_end_done", done, 1);

        // Run 3: error, start while busy, skewed rfd, long producer hold, reset in SEND.
        start = 1'b1; tick(); start = 1'b0;
        chk("run3_err_clr", err, 0);
        pair(1'b0, 8'd3, 8'd5, 10'd99);
        chk("run3_err", err, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("busy_start_err", err, 1);
        chk("busy_start_x", d1, 4);
        chk("busy_start_y", d2, 7);
        dav_in_n = 1'b0; tick();
        chk("stray_dav_in_rfd", rfd_in, 1);
        dav_in_n = 1'b1;
        rfd1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("skew_dav1", dav1, 1);
            chk("skew_dav2", dav2, 1);
        end
        rfd2 = 1'b1; tick();
        chk("skew_fall_dav1", dav1, 0);
        chk("skew_fall_dav2", dav2, 0);
        tick(); tick();
        chk("hold_dav1", dav1, 0);
        chk("hold_x", d1, 4);
        chk("hold_y", d2, 7);
        rfd1 = 1'b0; tick();
        chk("half_rel_dav1", dav1, 0);
        chk("half_rel_dav2", dav2, 0);
        rfd2 = 1'b0; tick();
        chk("both_rel_dav1", dav1, 1);
        chk("both_rel_dav2", dav2, 1);
        din = 10'd22; dav_in_n = 1'b0; tick();
        chk("long_rfd_in_fall", rfd_in, 0);
        chk("long_last", last, 22);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("long_rfd_in_low", rfd_in, 0);
        end
        dav_in_n = 1'b1; tick();
        chk("long_rfd_in_rise", rfd_in, 1);
        chk("long_err", err, 1);
        chk("long_next_x", d1, 5);
        chk("long_next_y", d2, 9);
        rfd1 = 1'b1; rfd2 = 1'b1; tick();
        chk("pre_rst_dav", dav1, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_dav1", dav1, 1);
        chk("mid_rst_dav2", dav2, 1);
        chk("mid_rst_rfd_in", rfd_in, 1);
        chk("mid_rst_x", d1, 3);
        chk("mid_rst_y", d2, 5);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_last", last, 0);
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dav1", dav1, 1);
        rfd1 = 1'b0; rfd2 = 1'b0;

        // Instance b: 255+255 carry, then wrap to (0,1).
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("b_busy", b_busy, 1);
        pair(1'b1, 8'd255, 8'd255, 10'd1020);
        chk("b_err0", b_err, 0);
        pair(1'b1, 8'd0, 8'd1, 10'd2);
        chk("b_done", b_done, 1);
        chk("b_busy_end", b_busy, 0);
        chk("b_err", b_err, 0);
        chk("b_last", b_last, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
